commit_alloc: RTL
=================

# commit_alloc

Commit-slot allocator for one hart. It owns the circular pool of NCOMMIT commit stations. It supplies the rename stage with the first free slot (`next_start`) and the free count (`current_available`), and consumes the per-cycle allocation count from rename control. It also retires the oldest slots as the commit logic completes them and rolls the allocation pointer back on branch mispredict or trap. It sits directly upstream of rename control and the rename slices, and beside the commit stations.

## Interface

Parameters:
- NCOMMIT, 32, number of commit stations; power of two.
- LNCOMMIT, 5, log2(NCOMMIT).
- NRETIRE, 8, maximum slots retired per clock.
- LNRETIRE, 4, width of retire count; holds 0..NRETIRE.

Ports (reset is synchronous, active-high; clock is clk):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- alloc_count, in, LNCOMMIT, slots allocated this cycle by rename control; 0 means none.
- retire_count, in, LNRETIRE, oldest slots committed this cycle.
- flush, in, 1, mispredict/trap rollback request.
- flush_addr, in, LNCOMMIT, slot of the redirecting instruction.
- flush_keep, in, 1, 1 = the flush_addr slot survives (branch); 0 = it is discarded (trap).
- next_start, out, LNCOMMIT, tail pointer: first slot of the next allocation.
- current_start, out, LNCOMMIT, head pointer: oldest live slot.
- current_available, out, LNCOMMIT+1, free slots, NCOMMIT − count.
- commit_valid, out, NCOMMIT, bitmap of live slots.
- empty, out, 1, count == 0.
- full, out, 1, count == NCOMMIT.
- alloc_err, out, 1, sticky protocol-violation flag.

## Operation

State and arithmetic:
- Registers: head, tail (LNCOMMIT bits each), count (LNCOMMIT+1 bits), valid bitmap, sticky error.
- All pointer arithmetic is mod NCOMMIT; wrap is natural overflow of LNCOMMIT bits.
- Empty and full are distinguished only by count; head == tail in both.

Per-cycle update, evaluated together:
- Retire:
  - r = min(retire_count, count).
  - head += r; clear valid bits head..head+r−1 (wrapping).
  - retire_count > count sets alloc_err.
- Flush: taking priority over alloc, which is ignored that cycle.
  - d = ((flush_addr − head) mod NCOMMIT) + flush_keep, computed in LNCOMMIT+1 bits, range 0..NCOMMIT.
  - If flush_addr is not live (valid bit clear) and count != 0: flush is ignored and alloc_err is set.
  - Otherwise: tail = head + d; clear every valid bit from the new tail through the old tail−1.
  - count = d − min(r, d).
  - If the retire consumed past the flush point, head = tail.
- Alloc, when no flush:
  - Legal only if alloc_count ≤ NCOMMIT − count + r.
  - Otherwise the allocation is dropped entirely and alloc_err is set.
  - If legal: set valid bits tail..tail+alloc_count−1; tail += alloc_count; count += alloc_count − r.
- Alloc and retire in the same cycle: both apply. A slot freed by retire may be reallocated in the same cycle because full wrap is permitted.

## Timing

- All outputs are registered. alloc/retire/flush sampled at edge N are reflected in every output after edge N.
- Zero-cycle combinational paths from inputs to outputs are forbidden. rename control compares against current_available in the same cycle it produces alloc_count.
- Reset values:
  - head = tail = 0, count = 0.
  - next_start = 0, current_start = 0, current_available = NCOMMIT.
  - commit_valid = 0, empty = 1, full = 0, alloc_err = 0.
- Reset mid-operation discards all live slots in one cycle. Inputs in the reset cycle are ignored.
- alloc_err clears only on reset.
- After a flush, the allocator accepts a new alloc_count the very next cycle. The reload bubble is imposed by rename control, not here.

## Test plan

- Reset, then alloc_count=4 for 3 cycles -> next_start=12, current_available=20, commit_valid=0x00000FFF, empty=0.
- Fill to 32 with retire 0 -> full=1, current_available=0. Next cycle, alloc_count=1 -> dropped, alloc_err=1, tail unchanged.
- Wrap: head=28, tail=28, count=0. Alloc 8 -> next_start=4, commit_valid=0xF000000F. Retire 8 -> empty=1, current_start=4.
- Simultaneous events, count=10: alloc_count=3 with retire_count=5 -> count=8, current_available=24.
- Flush with keep: head=2, tail=12. flush_addr=5, flush_keep=1, alloc_count=4 -> next_start=6, count=4, alloc ignored, bits 6..11 cleared.
- Trap flush: flush_addr=2, flush_keep=0, retire_count=0 -> empty=1, next_start=2.
- Illegal flush: flush_addr not live -> state unchanged, alloc_err=1.

Source files
------------

// File: rtl/commit_alloc.sv
// Commit-slot allocator: circular pool of NCOMMIT commit stations with head/tail/count,
// a live-slot bitmap, per-cycle alloc/retire, and branch/trap rollback of the tail.

module commit_alloc_slot #(
  parameter int LNCOMMIT = 5,
  parameter int IDX      = 0
) (
  input  logic [LNCOMMIT-1:0] i_head,
  input  logic [LNCOMMIT-1:0] i_tail,
  input  logic [LNCOMMIT:0]   i_ret,
  input  logic [LNCOMMIT:0]   i_dist,
  input  logic [LNCOMMIT-1:0] i_alloc_count,
  input  logic                i_alloc_ok,
  input  logic                i_flush_ok,
  input  logic                i_valid,
  output logic                o_valid
);
  logic [LNCOMMIT-1:0] w_off_h;
  logic [LNCOMMIT-1:0] w_off_t;
  logic                w_retired;
  logic                w_kept;
  logic                w_alloced;

  // Offsets from head/tail turn wrapping ranges into simple magnitude compares.
  assign w_off_h   = LNCOMMIT'(IDX) - i_head;
  assign w_off_t   = LNCOMMIT'(IDX) - i_tail;
  assign w_retired = {1'b0, w_off_h} < i_ret;
  assign w_kept    = {1'b0, w_off_h} < i_dist;
  assign w_alloced = i_alloc_ok && (w_off_t < i_alloc_count);

  always_comb begin
    if (i_flush_ok) o_valid = i_valid && !w_retired && w_kept;
    else            o_valid = (i_valid && !w_retired) || w_alloced;
  end
endmodule

module commit_alloc #(
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int NRETIRE  = 8,
  parameter int LNRETIRE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LNCOMMIT-1:0] alloc_count,
  input  logic [LNRETIRE-1:0] retire_count,
  input  logic                flush,
  input  logic [LNCOMMIT-1:0] flush_addr,
  input  logic                flush_keep,
  output logic [LNCOMMIT-1:0] next_start,
  output logic [LNCOMMIT-1:0] current_start,
  output logic [LNCOMMIT:0]   current_available,
  output logic [NCOMMIT-1:0]  commit_valid,
  output logic                empty,
  output logic                full,
  output logic                alloc_err
);
  localparam int CW = LNCOMMIT + 1;
  localparam logic [CW-1:0] NC = CW'(NCOMMIT);
  localparam logic [CW-1:0] NR = (NRETIRE < NCOMMIT) ? CW'(NRETIRE) : CW'(NCOMMIT);

  logic [LNCOMMIT-1:0] r_head, r_tail;
  logic [CW-1:0]       r_count;
  logic [NCOMMIT-1:0]  r_valid;
  logic                r_err;
  logic [CW-1:0]       r_avail;
  logic                r_empty, r_full;

  logic [CW-1:0]       w_ret_req;
  logic [CW-1:0]       w_ret;
  logic                w_ret_err;
  logic                w_flush_live;
  logic                w_flush_ok;
  logic                w_flush_bad;
  logic [CW-1:0]       w_dist;
  logic [CW:0]         w_room;
  logic                w_alloc_ok;
  logic                w_alloc_bad;
  logic [LNCOMMIT-1:0] w_head_n, w_tail_n;
  logic [CW-1:0]       w_count_n;
  logic [NCOMMIT-1:0]  w_valid_n;

  // Retire is bounded by live slots and by the commit path's per-clock limit.
  assign w_ret_req = CW'(retire_count);
  assign w_ret_err = w_ret_req > r_count;
  always_comb begin
    w_ret = (w_ret_req < r_count) ? w_ret_req : r_count;
    if (w_ret > NR) w_ret = NR;
  end

  // With an empty pool there is nothing to check the flush point against.
  assign w_flush_live = r_valid[flush_addr] || (r_count == '0);
  assign w_flush_ok   = flush && w_flush_live;
  assign w_flush_bad  = flush && !w_flush_live;
  assign w_dist       = {1'b0, flush_addr - r_head} + CW'(flush_keep);

  assign w_room      = {1'b0, NC - r_count} + {1'b0, w_ret};
  assign w_alloc_ok  = !flush && ({1'b0, CW'(alloc_count)} <= w_room);
  assign w_alloc_bad = !flush && !w_alloc_ok;

  always_comb begin
    w_head_n  = r_head + w_ret[LNCOMMIT-1:0];
    w_tail_n  = r_tail;
    w_count_n = r_count - w_ret;
    if (w_flush_ok) begin
      w_tail_n  = r_head + w_dist[LNCOMMIT-1:0];
      w_count_n = (w_ret > w_dist) ? '0 : (w_dist - w_ret);
      if (w_ret > w_dist) w_head_n = r_head + w_dist[LNCOMMIT-1:0];
    end else if (w_alloc_ok) begin
      w_tail_n  = r_tail + alloc_count;
      w_count_n = r_count + CW'(alloc_count) - w_ret;
    end
  end

  for (genvar i = 0; i < NCOMMIT; i++) begin : g_slot
    commit_alloc_slot #(.LNCOMMIT(LNCOMMIT), .IDX(i)) u_slot (
      .i_head       (r_head),
      .i_tail       (r_tail),
      .i_ret        (w_ret),
      .i_dist       (w_dist),
      .i_alloc_count(alloc_count),
      .i_alloc_ok   (w_alloc_ok),
      .i_flush_ok   (w_flush_ok),
      .i_valid      (r_valid[i]),
      .o_valid      (w_valid_n[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
      r_avail <= NC;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
      r_valid <= w_valid_n;
      r_err   <= r_err || w_ret_err || w_flush_bad || w_alloc_bad;
      r_avail <= NC - w_count_n;
      r_empty <= (w_count_n == '0);
      r_full  <= (w_count_n == NC);
    end
  end

  assign next_start        = r_tail;
  assign current_start     = r_head;
  assign current_available = r_avail;
  assign commit_valid      = r_valid;
  assign empty             = r_empty;
  assign full              = r_full;
  assign alloc_err         = r_err;
endmodule
